// File: rtl/button_sync_pkg.sv
// ---------------------------------------------------------------
// button_sync_pkg : sizing helper shared by the button_sync files
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package button_sync_pkg;

  // Bits needed to hold the values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_sync_ch.sv
// ---------------------------------------------------------------
// button_sync_ch : one button channel -- 2-flop synchronizer,
//                  debounce filter and registered press pulse
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module button_sync_ch
  import button_sync_pkg::*;
#(
  parameter int P_DEBOUNCE_CNT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press_pulse
);

  localparam int CNT_W = cnt_width(P_DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(P_DEBOUNCE_CNT - 1);

  logic             sync1;
  logic             sync2;
  logic             filtered;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      filtered    <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (sync2 == filtered) begin
        // Any bounce back to the accepted level restarts the count.
        cnt <= '0;
      end else if (cnt == C_CNT_LAST) begin
        filtered    <= sync2;
        cnt         <= '0;
        press_pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_sync.sv
// ---------------------------------------------------------------
// button_sync : array of independent debounced button channels
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module button_sync #(
  parameter int P_BUTTON_WIDTH = 5,
  parameter int P_DEBOUNCE_CNT = 2
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [P_BUTTON_WIDTH-1:0] iButtonRaw,
  output logic [P_BUTTON_WIDTH-1:0] oButtonEdge
);

  generate
    for (genvar i = 0; i < P_BUTTON_WIDTH; i++) begin : g_channel
      button_sync_ch #(
        .P_DEBOUNCE_CNT (P_DEBOUNCE_CNT)
      ) u_ch (
        .clk         (iClk),
        .rst         (iRst),
        .raw         (iButtonRaw[i]),
        .press_pulse (oButtonEdge[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_sync.sv
// ---------------------------------------------------------------
// tb_button_sync : directed self-checking bench for button_sync
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_button_sync;

  logic       clk;
  logic       rst;
  logic [4:0] raw;
  logic [4:0] btn_edge;

  int checks = 0;
  int errors = 0;

  button_sync #(
    .P_BUTTON_WIDTH (5),
    .P_DEBOUNCE_CNT (2)
  ) dut (
    .iClk        (clk),
    .iRst        (rst),
    .iButtonRaw  (raw),
    .oButtonEdge (btn_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw = 5'b00000;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (btn_edge !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected 00000", c, btn_edge);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (btn_edge !== 5'b00000) begin
        errors++;
        $display("FAIL reset_after cycle %0d: got %b expected 00000", c, btn_edge);
      end
    end
  endtask

  // raw[0] high for 3 sampling edges; pulse lands after the 4th edge (c=3).
  task automatic test_single_press();
    logic [4:0] exp;
    for (int c = 0; c < 14; c++) begin
      raw = (c < 3) ? 5'b00001 : 5'b00000;
      tick();
      exp = (c == 3) ? 5'b00001 : 5'b00000;
      checks++;
      if (btn_edge !== exp) begin
        errors++;
        $display("FAIL single_press cycle %0d: got %b expected %b", c, btn_edge, exp);
      end
    end
  endtask

  task automatic test_sequential();
    logic [4:0] exp;
    for (int c = 0; c < 26; c++) begin
      raw = 5'b00000;
      if (c < 3) raw = 5'b00100;
      else if (c >= 12 && c < 15) raw = 5'b10000;
      tick();
      exp = 5'b00000;
      if (c == 3) exp = 5'b00100;
      else if (c == 15) exp = 5'b10000;
      checks++;
      if (btn_edge !== exp) begin
        errors++;
        $display("FAIL sequential cycle %0d: got %b expected %b", c, btn_edge, exp);
      end
    end
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 10; c++) begin
      raw = (c == 0) ? 5'b00010 : 5'b00000;
      tick();
      checks++;
      if (btn_edge !== 5'b00000) begin
        errors++;
        $display("FAIL glitch cycle %0d: got %b expected 00000", c, btn_edge);
      end
    end
  endtask

  // Pattern 1,0,1,1: the low sample restarts the count, so acceptance
  // happens two edges after the second rise (c=5), not at c=4.
  task automatic test_bounce();
    logic [4:0] exp;
    for (int c = 0; c < 14; c++) begin
      raw = (c == 0 || c == 2 || c == 3) ? 5'b00010 : 5'b00000;
      tick();
      exp = (c == 5) ? 5'b00010 : 5'b00000;
      checks++;
      if (btn_edge !== exp) begin
        errors++;
        $display("FAIL bounce cycle %0d: got %b expected %b", c, btn_edge, exp);
      end
    end
  endtask

  task automatic test_simultaneous_hold();
    logic [4:0] exp;
    for (int c = 0; c < 30; c++) begin
      raw = (c < 20) ? 5'b01001 : 5'b00000;
      tick();
      exp = (c == 3) ? 5'b01001 : 5'b00000;
      checks++;
      if (btn_edge !== exp) begin
        errors++;
        $display("FAIL simultaneous_hold cycle %0d: got %b expected %b", c, btn_edge, exp);
      end
    end
  endtask

  // Reset lands on the edge where the counter holds 1 (c=3); the first
  // edge after release (c=4) restarts the synchronizer, so the pulse is at c=7.
  task automatic test_reset_mid_debounce();
    logic [4:0] exp;
    for (int c = 0; c < 24; c++) begin
      raw = (c < 16) ? 5'b00001 : 5'b00000;
      rst = (c == 3);
      tick();
      exp = (c == 7) ? 5'b00001 : 5'b00000;
      checks++;
      if (btn_edge !== exp) begin
        errors++;
        $display("FAIL reset_mid_debounce cycle %0d: got %b expected %b", c, btn_edge, exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    raw = 5'b00000;
    test_reset();
    test_single_press();
    test_sequential();
    test_glitch();
    test_bounce();
    test_simultaneous_hold();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_sync.md
BUTTON_SYNC -- requirements
Module: button_sync

Interface
REQ-001 Parameter P_BUTTON_WIDTH, default 5: number of independent button channels, legal range 1 and up.
REQ-002 Parameter P_DEBOUNCE_CNT, default 2: consecutive cycles a synchronized level must differ from the filtered state before it is accepted, legal range 1 and up.
REQ-003 iClk  input  1  sole clock; all state updates on rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iButtonRaw  input  P_BUTTON_WIDTH  asynchronous raw button levels, 1 = pressed.
REQ-006 oButtonEdge  output  P_BUTTON_WIDTH  registered one-cycle press pulse per channel.

Function
REQ-007 Each bit SHALL be processed by an identical, fully independent channel with no cross-channel interaction.
REQ-008 Each channel SHALL pass iButtonRaw[i] through a 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-009 Each channel SHALL hold a filtered state bit and a debounce counter of width clog2(P_DEBOUNCE_CNT+1).
REQ-010 When sync2 equals the filtered state, the counter SHALL clear to 0.
REQ-011 When sync2 differs from the filtered state, the counter SHALL increment; at the edge where it would reach P_DEBOUNCE_CNT, the filtered state SHALL take sync2 and the counter SHALL clear.
REQ-012 oButtonEdge[i] SHALL be 1 for exactly the one cycle following the clock edge at which the filtered state changes 0->1, and 0 otherwise.
REQ-013 A filtered 1->0 change (release) SHALL NOT produce a pulse.
REQ-014 Latency: if raw rises before posedge k and stays high, oButtonEdge SHALL be high during the cycle after posedge k+1+P_DEBOUNCE_CNT; for the default this is the cycle after posedge k+3.
REQ-015 Raw pulses high for fewer than P_DEBOUNCE_CNT sampling edges SHALL NOT change the filtered state or produce a pulse.
REQ-016 Bouncing (sync2 toggling back to the filtered value) SHALL restart the count from 0.
REQ-017 Holding a button produces a single pulse; no new pulse until a debounced release and a new debounced press occur.
REQ-018 Simultaneous presses on several channels SHALL produce simultaneous pulses on those channels.

Reset
REQ-019 While iRst=1 at a rising edge, sync1, sync2, filtered state, counter and oButtonEdge of every channel SHALL clear to 0.
REQ-020 oButtonEdge SHALL be all-zero in the cycle after any reset edge.
REQ-021 A button held high through reset deassertion SHALL be treated as a fresh press and produce one pulse after the REQ-014 latency.
REQ-022 Reset asserted mid-debounce SHALL discard the count and any pending pulse.

Structure
REQ-023 No shared package is required; both parameters are module-local.
REQ-024 The per-channel logic SHALL be one sub-module, button_sync_ch, instantiated P_BUTTON_WIDTH times by a generate loop in button_sync.
REQ-025 All logic is synchronous to iClk with no latches and no combinational path from iButtonRaw to oButtonEdge.

Verification
REQ-026 Reset held 4 cycles with iButtonRaw=0 -> oButtonEdge=5'b00000 during and after reset.
REQ-027 iButtonRaw[0] high for 3 rising edges, then low -> exactly one cycle of oButtonEdge=5'b00001, timed per REQ-014; nothing on release.
REQ-028 Sequential 3-cycle presses on bits 2 and then 4 -> one pulse each, 5'b00100 then 5'b10000, with no other bits active.
REQ-029 1-cycle glitch on bit 1 -> oButtonEdge stays 0.
REQ-030 Bits 0 and 3 raised on the same edge and held 20 cycles -> a single simultaneous 5'b01001 pulse with no repeat.
REQ-031 Reset asserted at the edge where the counter equals 1 -> no pulse; after release with the button still high, one pulse per REQ-021.
